// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int unsigned width,
                                  input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/ripple_slice.sv
// Combinational W-bit ripple-carry adder; also exposes the carry into its MSB.
module ripple_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < int'(W); i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit adder/subtractor split into STAGES ripple slices with registered
// inter-slice carries and a valid/ready handshake under global stall.
module pipelined_adder_sub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero
);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_adder_sub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  localparam int unsigned S    = slice_width(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;

  op_e  op;
  logic advance;

  logic [STAGES-1:0]            v_q, v_in, c_q, c_in, c_out, c_msb;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, sum_in, sum_nx;
  logic [STAGES-1:0][S-1:0]     slice_sum;
  logic                         ovf_q, zero_q;
  logic                         unused_bits;

  assign op      = op_e'(i_sub);
  assign advance = !v_q[LAST] | i_ready;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({S{1'b1}}) << (k * S);

    if (k == 0) begin : g_entry
      // Subtraction is A + ~B + 1; i_carry only matters for addition.
      assign v_in[0]   = i_valid & advance;
      assign a_in[0]   = i_data_a;
      assign b_in[0]   = (op == OP_SUB) ? ~i_data_b : i_data_b;
      assign c_in[0]   = (op == OP_SUB) ? 1'b1 : i_carry;
      assign sum_in[0] = '0;
    end else begin : g_link
      assign v_in[k]   = v_q[k-1];
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign sum_in[k] = sum_q[k-1];
    end

    ripple_slice #(.W(S)) u_slice (
      .a    (a_in[k][k*S +: S]),
      .b    (b_in[k][k*S +: S]),
      .cin  (c_in[k]),
      .sum  (slice_sum[k]),
      .cout (c_out[k]),
      .cmsb (c_msb[k])
    );

    assign sum_nx[k] = (sum_in[k] & ~MASK) | (WIDTH'(slice_sum[k]) << (k * S));
  end

  // Global stall: every stage and the output flags move only on advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      v_q    <= v_in;
      c_q    <= c_out;
      a_q    <= a_in;
      b_q    <= b_in;
      sum_q  <= sum_nx;
      ovf_q  <= c_msb[LAST] ^ c_out[LAST];
      zero_q <= (sum_nx[LAST] == '0);
    end
  end

  // Operands are dead once the final slice has consumed them.
  assign unused_bits = ^{a_q[LAST], b_q[LAST], c_msb};

  assign o_ready    = advance;
  assign o_valid    = v_q[LAST];
  assign o_data     = sum_q[LAST];
  assign o_carry    = c_q[LAST];
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
Parametrised, pipelined WIDTH-bit adder/subtractor.
- Splits the operation into STAGES ripple slices of WIDTH/STAGES bits each.
- Registers the carry between slices, giving one result per cycle at STAGES-cycle latency.
- Valid/ready handshake on input and output with full backpressure.
- Produces carry, signed-overflow and zero flags.
- Used as the datapath adder where a single-cycle WIDTH-bit ripple chain misses timing.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline slices and latency in cycles; 1..WIDTH.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  input operands valid.
o_ready  output  1  block accepts input this cycle.
i_data_a  input  WIDTH  operand A.
i_data_b  input  WIDTH  operand B.
i_carry  input  1  carry-in; used in ADD mode only.
i_sub  input  1  0 = ADD (A+B+i_carry), 1 = SUB (A-B).
o_valid  output  1  result valid.
i_ready  input  1  downstream accepts result.
o_data  output  WIDTH  sum/difference.
o_carry  output  1  carry-out of MSB; in SUB mode 1 = no borrow.
o_overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
o_zero  output  1  o_data == 0.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - All stage valid bits clear.
  - o_valid = 0; o_data, o_carry, o_overflow, o_zero = 0.
  - Reset mid-operation discards every in-flight op; no result is ever emitted for them.
- SUB mode:
  - B is bitwise inverted at entry.
  - Carry-in forced to 1; i_carry is ignored.
- Advance rule:
  - advance = !o_valid | i_ready.
  - o_ready = advance (combinational).
  - An input transfer occurs when i_valid & o_ready.
- Pipeline:
  - Stage k (0..STAGES-1) adds operand bits [k*S +: S], S = WIDTH/STAGES.
  - Its carry-in is the carry registered by stage k-1 (stage 0 uses the entry carry).
  - The unprocessed upper operand bits and completed lower sum bits travel with the op.
  - Each stage register carries a valid bit.
  - On advance, every stage loads from its predecessor.
  - Stage 0 loads i_valid & o_ready; a bubble is a stage whose valid bit is 0.
  - When advance = 0, all stages and all outputs hold. This is a global stall: no bubble collapsing.
- Latency and throughput:
  - An op accepted at edge n is presented on o_valid/o_data after edge n+STAGES−1 (STAGES edges including acceptance), provided no stall occurs.
  - Throughput is 1 op/cycle.
- Outputs:
  - Registered, updated only on advance; stable while o_valid & !i_ready.
  - o_overflow is computed from the carry into and out of bit WIDTH−1 in the final slice.
  - o_zero is computed from the full result in the final stage.
- Ordering: results leave in acceptance order; none dropped or duplicated.
- Simultaneous events: when a transfer occurs on both input and output in the same cycle, both complete; occupancy is unchanged.
- STAGES = 1: degenerates to a single registered WIDTH-bit adder with a 1-cycle output register.

Decomposition:
- Package adder_pkg:
  - typedef enum logic {OP_ADD, OP_SUB} op_e.
  - A function returning slice width.
  - An elaboration-time check that WIDTH % STAGES == 0.
- Sub-module ripple_slice:
  - Parameter W.
  - Combinational W-bit ripple adder built from full-adder cells.
  - Outputs sum, carry-out, and carry into its MSB (used for overflow).
  - Instantiated STAGES times in a generate loop.

Test Plan:
- Reset: hold i_rst_n=0 while driving i_valid=1 -> o_valid=0, o_data=0, all flags 0; after release, first result appears only after STAGES cycles.
- WIDTH=32, STAGES=4, ADD 0xFFFFFFFF + 0x00000001, i_carry=0 -> 4 cycles later o_data=0x00000000, o_carry=1, o_zero=1, o_overflow=0.
- SUB 0x80000000 − 0x00000001 -> o_data=0x7FFFFFFF, o_carry=1, o_overflow=1, o_zero=0. SUB 0x5 − 0x7 -> o_data=0xFFFFFFFE, o_carry=0.
- ADD 5 + 7 with i_carry=1 -> o_data=13. Same operands with i_sub=1, i_carry=1 -> o_data=0xFFFFFFFE (i_carry ignored).
- Stream 8 back-to-back ops; drop i_ready for 3 cycles while o_valid=1 -> o_ready=0 during the stall, o_data held, all 8 results in order, none lost or duplicated.
- Reset pulse with 3 ops in flight -> o_valid=0 immediately (asynchronously); no stale result after release; a new op's result is correct.
